// File: rtl/rc4_prga_engine_if.sv
// Bus bundle for rc4_prga_engine: run handshake, S RAM port, ciphertext ROM port, plaintext RAM port.
// master = engine side, slave = memories/controller side.
interface rc4_prga_engine_if #(
  parameter int K_W = 8
);
  logic           start;
  logic           busy;
  logic           done;
  logic           ok;
  logic [7:0]     s_addr;
  logic [7:0]     s_data;
  logic           s_wren;
  logic [7:0]     s_q;
  logic [K_W-1:0] rom_addr;
  logic [7:0]     rom_q;
  logic [K_W-1:0] out_addr;
  logic [7:0]     out_data;
  logic           out_wren;

  modport master (
    input  start, s_q, rom_q,
    output busy, done, ok, s_addr, s_data, s_wren, rom_addr, out_addr, out_data, out_wren
  );

  modport slave (
    output start, s_q, rom_q,
    input  busy, done, ok, s_addr, s_data, s_wren, rom_addr, out_addr, out_data, out_wren
  );
endinterface

// File: rtl/rc4_prga_engine.sv
// RC4 keystream (PRGA) decryptor: 10 cycles per byte, S held in an external synchronous RAM.
// Optional macro RC4_VALID_CHECK_EN: stop with ok=0 on the first plaintext byte outside a-z / space.
module rc4_prga_engine #(
  parameter int MSG_LEN = 32,
  parameter int K_W     = 8
) (
  input logic               clock,
  input logic               reset,
  rc4_prga_engine_if.master bus
);

  // state  | meaning
  // IDLE   | waiting for start
  // INC_I  | i <= i+1
  // RD_I   | read S[i]
  // LD_SI  | capture S[i], update j
  // RD_J   | read S[j]
  // LD_SJ  | capture S[j]
  // WR_I   | S[i] <= S[j]
  // WR_J   | S[j] <= S[i]
  // RD_F   | read S[S[i]+S[j]]
  // LD_F   | capture keystream byte
  // WR_OUT | write plaintext, advance k or finish
  // DONE   | one-cycle done pulse
  typedef enum logic [3:0] {
    IDLE, INC_I, RD_I, LD_SI, RD_J, LD_SJ, WR_I, WR_J, RD_F, LD_F, WR_OUT, DONE
  } state_t;

  localparam logic [K_W-1:0] K_LAST = K_W'(MSG_LEN - 1);

  state_t         state, state_nxt;
  logic [7:0]     i, j, si, sj, f;
  logic [K_W-1:0] k;
  logic           ok_r;

  logic [7:0]     s_addr_c, s_data_c;
  logic           s_wren_c, out_wren_c;
  logic [7:0]     plain;
  logic           byte_bad;
  logic           last_byte;

  assign plain     = f ^ bus.rom_q;
  assign last_byte = (k == K_LAST);

`ifdef RC4_VALID_CHECK_EN
  assign byte_bad = !(((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20));
`else
  assign byte_bad = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i    <= 8'h00;
      j    <= 8'h00;
      k    <= '0;
      si   <= 8'h00;
      sj   <= 8'h00;
      f    <= 8'h00;
      ok_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            i    <= 8'h00;
            j    <= 8'h00;
            k    <= '0;
            ok_r <= 1'b0;
          end
        end
        INC_I: i <= i + 8'h01;
        LD_SI: begin
          si <= bus.s_q;
          j  <= j + bus.s_q;
        end
        LD_SJ: sj <= bus.s_q;
        LD_F:  f  <= bus.s_q;
        WR_OUT: begin
          // ok is only decided when the run ends; a bad byte ends it early
          if (last_byte || byte_bad) begin
            ok_r <= !byte_bad;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    s_addr_c   = 8'h00;
    s_data_c   = 8'h00;
    s_wren_c   = 1'b0;
    out_wren_c = 1'b0;
    case (state)
      IDLE:   if (bus.start) state_nxt = INC_I;
      INC_I:  state_nxt = RD_I;
      RD_I: begin
        s_addr_c  = i;
        state_nxt = LD_SI;
      end
      LD_SI:  state_nxt = RD_J;
      RD_J: begin
        s_addr_c  = j;
        state_nxt = LD_SJ;
      end
      LD_SJ:  state_nxt = WR_I;
      WR_I: begin
        s_addr_c  = i;
        s_data_c  = sj;
        s_wren_c  = 1'b1;
        state_nxt = WR_J;
      end
      WR_J: begin
        s_addr_c  = j;
        s_data_c  = si;
        s_wren_c  = 1'b1;
        state_nxt = RD_F;
      end
      RD_F: begin
        s_addr_c  = si + sj;
        state_nxt = LD_F;
      end
      LD_F:   state_nxt = WR_OUT;
      WR_OUT: begin
        out_wren_c = 1'b1;
        state_nxt  = (last_byte || byte_bad) ? DONE : INC_I;
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.ok       = ok_r;
  assign bus.s_addr   = s_addr_c;
  assign bus.s_data   = s_data_c;
  assign bus.s_wren   = s_wren_c;
  assign bus.rom_addr = k;
  assign bus.out_addr = k;
  assign bus.out_wren = out_wren_c;
  // plaintext bus is forced to zero outside the write so it idles at its reset value
  assign bus.out_data = out_wren_c ? plain : 8'h00;

endmodule

// File: doc/rc4_prga_engine.md
RC4_PRGA_ENGINE -- requirements
Module: rc4_prga_engine

Interface
REQ-001 Parameter MSG_LEN, default 32, number of bytes to decrypt; legal range 1..2^K_W.
REQ-002 Parameter K_W, default 8, width of the message-index counter k and of the rom/out address ports.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-005 start  in  1  request to run; sampled only in IDLE.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 done  out  1  one-cycle pulse at the end of a run.
REQ-008 ok  out  1  run result, valid while done=1 and held until the next accepted start.
REQ-009 s_addr  out  8  S RAM address.
REQ-010 s_data  out  8  S RAM write data.
REQ-011 s_wren  out  1  S RAM write enable.
REQ-012 s_q  in  8  S RAM read data; synchronous RAM, 1-cycle read latency.
REQ-013 rom_addr  out  K_W  ciphertext ROM address; always equal to k.
REQ-014 rom_q  in  8  ciphertext ROM data; 1-cycle latency.
REQ-015 out_addr  out  K_W  plaintext RAM address; always equal to k.
REQ-016 out_data  out  8  plaintext RAM write data, f XOR rom_q.
REQ-017 out_wren  out  1  plaintext RAM write enable.

Function
REQ-018 States: IDLE, INC_I, RD_I, LD_SI, RD_J, LD_SJ, WR_I, WR_J, RD_F, LD_F, WR_OUT, DONE.
REQ-019 IDLE with start=1: clear i, j and k, clear ok, and go to INC_I; with start=0, stay in IDLE.
REQ-020 INC_I: i <= i+1 (mod 256). RD_I: s_addr=i. LD_SI: si <= s_q and j <= j+s_q (mod 256).
REQ-021 RD_J: s_addr=j. LD_SJ: sj <= s_q.
REQ-022 WR_I: s_addr=i, s_data=sj, s_wren=1. WR_J: s_addr=j, s_data=si, s_wren=1.
REQ-023 RD_F: s_addr=si+sj (mod 256, 8-bit wrap). LD_F: f <= s_q.
REQ-024 WR_OUT: out_wren=1 and out_data=f^rom_q.
REQ-025 In WR_OUT, if k==MSG_LEN-1 (or on an early fail per REQ-036), go to DONE; otherwise k <= k+1 and go to INC_I.
REQ-026 Each byte takes exactly 10 cycles (INC_I..WR_OUT).
REQ-027 A full run asserts done in the cycle 10*MSG_LEN+1 after the cycle in which start was sampled.
REQ-028 DONE: done=1 for one cycle, then IDLE; start in DONE is ignored.
REQ-029 start while busy is ignored; it has no effect on state, registers or outputs.
REQ-030 s_wren and out_wren are never high in the same cycle; each is high in at most one cycle per write.
REQ-031 S RAM contents persist across runs; the block never re-initialises S.
REQ-032 Without an early fail, ok=1 at done.

Reset
REQ-033 reset=1 forces IDLE on the next edge from any state, including mid-run, and the aborted run produces no done pulse.
REQ-034 Reset values: i=j=k=si=sj=f=0; ok=0; done=busy=s_wren=out_wren=0; s_addr=s_data=out_data=0.
REQ-035 reset has priority over start in the same cycle.

Configuration
REQ-036 With macro RC4_VALID_CHECK_EN defined: in WR_OUT, a byte outside 8'h61..8'h7A that is not 8'h20 is still written, then the block goes directly to DONE with ok=0.
REQ-037 Without RC4_VALID_CHECK_EN: no byte check is made, every run processes MSG_LEN bytes, and ok=1 at done.

Verification
REQ-038 MSG_LEN=4, S[x]=x, ROM all 00, check off, start -> out[0..3]=02,05,07,0D; done at cycle 41; ok=1.
REQ-039 Same S, ROM=63,64,66,6C, check on -> out=61,61,61,61 (all valid), ok=1, done at cycle 41.
REQ-040 Same S, ROM all 00, check on -> exactly one out_wren (out[0]=02); done at cycle 11; ok=0.
REQ-041 Assert reset in cycle 15 of a run -> busy=0 next cycle; no done pulse; a fresh start then reproduces the REQ-038 output with S re-preloaded.
REQ-042 Pulse start at cycles 5 and 20 of a run -> no effect; a single done at cycle 41.
